instr_fanout_queue: RTL

- Clocked, parametrised successor to the single-word asynchronous instruction register.
- Buffers instruction words in a DEPTH-entry FIFO and presents the head word to N_CONS consumers (decode, ALU and memory stages by default).
- Retires the head only after every consumer has acknowledged it. This is a clocked completion-detect equivalent of the Muller-element join.
- Filters bubble words: a word whose opcode field is all-zero is accepted but never stored.

---
 rtl/instr_fanout_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_fanout_queue.sv
// ============================================================================
// instr_fanout_queue
// ----------------------------------------------------------------------------
// Purpose:
//   Clocked, parametrised instruction buffer that replaces the old single-word
//   asynchronous instruction register. Incoming instruction words are held in
//   a DEPTH-entry circular FIFO. The head word is broadcast to N_CONS
//   consumers (decode, ALU and memory stages by default). The head is retired
//   only once every consumer has acknowledged it. This is the clocked
//   equivalent of a Muller C-element join across all consumers.
//
//   Bubble words (opcode field all zero) are accepted from the producer but
//   never stored, so they cost the producer one handshake and nothing else.
//
// Parameters:
//   WIDTH   - instruction word width in bits
//   DEPTH   - FIFO entries; must be a power of two and at least 2
//   N_CONS  - number of consumers that must acknowledge each word (1..8)
//   OPC_MSB - MSB of the opcode field used for bubble detection
//   OPC_LSB - LSB of the opcode field (OPC_LSB <= OPC_MSB < WIDTH)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   producer offers in_data this cycle
//   in_data     in   instruction word [WIDTH]
//   in_ready    out  queue can accept a word this cycle
//   out_valid   out  head word is present on out_data
//   out_data    out  head word [WIDTH], zero when the queue is empty
//   cons_ack    in   per-consumer acknowledge of the head [N_CONS]
//   ack_pending out  consumers that have not yet acknowledged the head
//   count       out  number of stored words [clog2(DEPTH)+1]
//   flush       in   synchronous discard of all contents
// ============================================================================
module instr_fanout_queue #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int N_CONS  = 3,
    parameter int OPC_MSB = 15,
    parameter int OPC_LSB = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic [N_CONS-1:0]        cons_ack,
    output logic [N_CONS-1:0]        ack_pending,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [N_CONS-1:0] done;

    logic has_room;
    logic det;
    logic push;
    logic pop;
    logic all_done;

    // Handshake and retirement decisions, all derived from registered state
    // plus the current inputs. in_ready deliberately ignores a pop happening
    // in the same cycle: a full queue never passes a word straight through,
    // which keeps in_ready free of any path from cons_ack.
    // A word is stored only when its opcode field is non-zero; a bubble still
    // completes the producer handshake but never touches memory or count.
    // The join fires when every consumer has either acked earlier (done) or
    // is acking right now (cons_ack). Flush overrides both push and pop.
    always_comb begin
        has_room = (count < DEPTH_C);
        in_ready = has_room & ~flush;
        det      = |in_data[OPC_MSB:OPC_LSB];
        push     = in_valid & in_ready & det;
        out_valid = (count != '0);
        all_done = &(done | cons_ack);
        pop      = out_valid & all_done & ~flush;
    end

    // Head presentation. The data bus is forced to zero when empty so that
    // stale memory contents never leak to the consumers, and the pending mask
    // is only meaningful while a head word exists.
    always_comb begin
        out_data    = out_valid ? mem[rd_ptr] : '0;
        ack_pending = out_valid ? ~done : '0;
    end

    // Storage array. It has no reset: every read is qualified by out_valid,
    // which is derived from count, so uninitialised entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping. Pointers are AW bits wide so they
    // wrap modulo DEPTH for free (DEPTH is a power of two). A simultaneous
    // store and retire leaves count unchanged; a retire alongside a bubble
    // simply decrements, because the bubble never raises push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Per-consumer acknowledge accumulator for the current head. Acks seen
    // while the queue is empty are dropped so an early pulse cannot pre-credit
    // a word that has not arrived yet. OR-ing means a repeated ack from a
    // consumer that already acked is harmless. The mask clears on retirement
    // so the next head starts with every consumer pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= '0;
        end else if (flush) begin
            done <= '0;
        end else if (pop) begin
            done <= '0;
        end else if (out_valid) begin
            done <= done | cons_ack;
        end
    end

endmodule
